smac_unit: RTL and testbench

SMAC_UNIT -- requirements
Module: smac_unit

---
 rtl/smac_unit_pkg.sv | 16 +
 rtl/smac_unit_if.sv | 28 ++
 rtl/smac_unit_booth_step.sv | 25 ++
 rtl/smac_unit.sv | 123 ++++++++++++
 tb/tb_smac_unit.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/smac_unit_pkg.sv
// Shared definitions for the sequential Booth multiply-accumulate unit:
// operation encodings and controller states.
package smac_unit_pkg;

  localparam logic [1:0] MODE_MUL    = 2'b00;
  localparam logic [1:0] MODE_MULADD = 2'b01;
  localparam logic [1:0] MODE_ACC    = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/smac_unit_if.sv
// Request/response bundle for smac_unit: the producer drives operations,
// the consumer takes products and mode-dependent results.
interface smac_unit_if #(
  parameter int W     = 4,
  parameter int ACC_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       a;
  logic [W-1:0]       b;
  logic [ACC_W-1:0]   addend;
  logic [1:0]         mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*W-1:0]     product;
  logic [ACC_W-1:0]   result;
  logic               ovf;

  modport master (
    output in_valid, a, b, addend, mode, out_ready,
    input  in_ready, out_valid, product, result, ovf
  );

  modport slave (
    input  in_valid, a, b, addend, mode, out_ready,
    output in_ready, out_valid, product, result, ovf
  );
endinterface

// File: rtl/smac_unit_booth_step.sv
// One radix-2 Booth step on {hi[W:0], lo[W-1:0], q_m1}. hi carries one guard
// bit so that -2^(W-1) * -2^(W-1) cannot overflow the running sum.
module booth_step #(
  parameter int W = 4
) (
  input  logic [W-1:0]   mcand,
  input  logic [2*W+1:0] pp_i,
  output logic [2*W+1:0] pp_o
);
  logic [W:0] hi;
  logic [W:0] m_ext;
  logic [W:0] hi_n;

  always_comb begin
    hi    = pp_i[2*W+1:W+1];
    m_ext = {mcand[W-1], mcand};
    case (pp_i[1:0])
      2'b01:   hi_n = hi + m_ext;
      2'b10:   hi_n = hi - m_ext;
      default: hi_n = hi;
    endcase
    // arithmetic shift right; the old lo[0] becomes the new q_m1
    pp_o = {hi_n[W], hi_n, pp_i[W:1]};
  end
endmodule

// File: rtl/smac_unit.sv
// Sequential signed multiply / multiply-add / accumulate unit. One Booth step
// per BUSY cycle; the result and accumulator are committed on DONE entry.
module smac_unit
  import smac_unit_pkg::*;
#(
  parameter int W     = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [ACC_W-1:0] addend,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   product,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);
  localparam int PP_W  = 2*W + 2;
  localparam int CNT_W = $clog2(W + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       a_q, a_d;
  logic [ACC_W-1:0]   addend_q, addend_d;
  logic [1:0]         mode_q, mode_d;
  logic [PP_W-1:0]    pp_q, pp_d, pp_nxt;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [2*W-1:0]     product_q, product_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   p_ext, opnd, sum;
  logic               sum_ovf;

  booth_step #(.W(W)) u_step (
    .mcand (a_q),
    .pp_i  (pp_q),
    .pp_o  (pp_nxt)
  );

  // MUL and LOAD add zero, which makes their overflow flag zero for free
  always_comb begin
    p_ext = ACC_W'(signed'(pp_q[2*W:1]));
    case (mode_q)
      MODE_MULADD: opnd = addend_q;
      MODE_ACC:    opnd = acc_q;
      default:     opnd = '0;
    endcase
    sum     = p_ext + opnd;
    sum_ovf = (p_ext[ACC_W-1] == opnd[ACC_W-1]) && (sum[ACC_W-1] != p_ext[ACC_W-1]);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    addend_d  = addend_q;
    mode_d    = mode_q;
    pp_d      = pp_q;
    acc_d     = acc_q;
    product_d = product_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d      = a;
        addend_d = addend;
        mode_d   = mode;
        pp_d     = {{(W+1){1'b0}}, b, 1'b0};
        cnt_d    = '0;
        state_d  = BUSY;
      end
      BUSY: if (cnt_q == CNT_W'(W)) begin
        product_d = pp_q[2*W:1];
        result_d  = sum;
        ovf_d     = sum_ovf;
        if (mode_q == MODE_ACC || mode_q == MODE_LOAD) acc_d = sum;
        state_d   = DONE;
      end else begin
        pp_d  = pp_nxt;
        cnt_d = cnt_q + 1'b1;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      addend_q  <= '0;
      mode_q    <= '0;
      pp_q      <= '0;
      acc_q     <= '0;
      product_q <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      addend_q  <= addend_d;
      mode_q    <= mode_d;
      pp_q      <= pp_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = product_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_smac_unit.sv
// Directed bench for smac_unit (W=4, ACC_W=8): a driver issues operations and
// queues hand-computed responses; a monitor pops and compares on each output handshake.
module tb_smac_unit;
  import smac_unit_pkg::*;
  localparam int W = 4;
  localparam int ACC_W = 8;

  typedef struct packed {
    logic [7:0] product;
    logic [7:0] result;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  smac_unit_if #(.W(W), .ACC_W(ACC_W)) bus ();

  smac_unit #(.W(W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .a         (bus.a),
    .b         (bus.b),
    .addend    (bus.addend),
    .mode      (bus.mode),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .product   (bus.product),
    .result    (bus.result),
    .ovf       (bus.ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // monitor: compare every accepted result against the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got result %0h, expected no output", bus.result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_product", {24'd0, bus.product}, {24'd0, e.product});
          chk("sb_result",  {24'd0, bus.result},  {24'd0, e.result});
          chk("sb_ovf",     {31'd0, bus.ovf},     {31'd0, e.ovf});
        end
      end
    end
  end

  // issue one operation and return the cycle count from acceptance to out_valid
  task automatic do_op(input logic [1:0] m, input logic [3:0] ia, input logic [3:0] ib,
                       input logic [7:0] ad, input logic [7:0] ep, input logic [7:0] er,
                       input logic eo, output int lat);
    int n;
    exp_q.push_back('{product: ep, result: er, ovf: eo});
    n = 0;
    while (!bus.in_ready && n < 40) begin @(posedge clk); #1; n++; end
    if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    bus.mode = m; bus.a = ia; bus.b = ib; bus.addend = ad; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = ~ia; bus.b = ib ^ 4'h6; bus.addend = ~ad;  // later changes must be ignored
    lat = 0;
    while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!bus.out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    bool_seen_blk: begin end
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.addend = '0;
    bus.mode = MODE_MUL; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_product",   {24'd0, bus.product},   32'd0);
    chk("rst_result",    {24'd0, bus.result},    32'd0);

    do_op(MODE_MUL, 4'b1101, 4'd5, 8'h00, 8'hF1, 8'hF1, 1'b0, lat);
    chk("mul_latency", lat, W + 1);
    do_op(MODE_MULADD, 4'b1101, 4'd5, 8'h12, 8'hF1, 8'h03, 1'b0, lat);
    chk("muladd_latency", lat, W + 1);
    do_op(MODE_MULADD, 4'b1000, 4'b1000, 8'h40, 8'h40, 8'h80, 1'b1, lat);

    @(posedge clk); #1;
    pulse_rst();
    do_op(MODE_ACC, 4'd7, 4'd7, 8'h00, 8'h31, 8'h31, 1'b0, lat);
    do_op(MODE_ACC, 4'd7, 4'd7, 8'h00, 8'h31, 8'h62, 1'b0, lat);
    do_op(MODE_ACC, 4'd7, 4'd7, 8'h00, 8'h31, 8'h93, 1'b1, lat);
    do_op(MODE_MUL, 4'd2, 4'd3, 8'h00, 8'h06, 8'h06, 1'b0, lat);
    do_op(MODE_ACC, 4'd1, 4'd1, 8'h00, 8'h01, 8'h94, 1'b0, lat);

    // backpressure: hold DONE for 10 cycles while inputs move
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    do_op(MODE_MUL, 4'b1101, 4'd5, 8'h00, 8'hF1, 8'hF1, 1'b0, lat);
    chk("bp_latency", lat, W + 1);
    for (int i = 0; i < 10; i++) begin
      bus.a = 4'(i); bus.b = 4'(~i); bus.in_valid = i[0];
      @(posedge clk); #1;
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
      chk("bp_product",   {24'd0, bus.product},   32'hF1);
      chk("bp_result",    {24'd0, bus.result},    32'hF1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // reset during the second BUSY cycle of an ACC aborts it and clears acc
    bus.mode = MODE_ACC; bus.a = 4'd7; bus.b = 4'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    pulse_rst();
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        if (bus.out_valid) seen++;
        @(posedge clk); #1;
      end
      chk("abort_no_out_valid", seen, 0);
    end
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    do_op(MODE_ACC,  4'd1, 4'd1, 8'h00, 8'h01, 8'h01, 1'b0, lat);
    do_op(MODE_LOAD, 4'd2, 4'd3, 8'h00, 8'h06, 8'h06, 1'b0, lat);
    do_op(MODE_ACC,  4'd1, 4'd1, 8'h00, 8'h01, 8'h07, 1'b0, lat);
    do_op(MODE_MUL,  4'b1000, 4'b1000, 8'h00, 8'h40, 8'h40, 1'b0, lat);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
